// File: rtl/dma_channel.sv
// Single-channel word-copy DMA over a shared bidirectional RAM bus.
// Each word costs four cycles: read, address setup, write, release.
module dma_channel #(
    parameter int SZ  = 8,
    parameter int WSZ = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [SZ-1:0]  src,
    input  logic [SZ-1:0]  dst,
    input  logic [SZ-1:0]  len,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [SZ-1:0]  ram_addr,
    output logic           ram_w_notr,
    inout  wire  [WSZ-1:0] ram_data
);

    typedef enum logic [2:0] {IDLE, RD, WSET, WR, WREL, FIN} state_t;

    state_t         state_q, state_d;
    logic [SZ-1:0]  src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [SZ-1:0]  i_q, i_d, i_inc;
    logic [SZ-1:0]  addr_q, addr_d;
    logic [WSZ-1:0] buf_q, buf_d;
    logic           wr_q, wr_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        buf_d   = buf_q;
        i_inc   = i_q + SZ'(1);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    i_d     = '0;
                    state_d = (len == '0) ? FIN : RD;
                end
            end
            RD: begin
                buf_d   = ram_data;
                state_d = WSET;
            end
            WSET: state_d = WR;
            WR:   state_d = WREL;
            WREL: begin
                i_d     = i_inc;
                state_d = (i_inc < len_q) ? RD : FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE)
            state_d = IDLE;

        // Address and direction are registered from the state being entered, so the
        // address only moves on edges where the write strobe is low on both sides.
        addr_d = addr_q;
        case (state_d)
            RD:       addr_d = src_d + i_d;
            WSET, WR: addr_d = dst_d + i_d;
            default:  addr_d = addr_q;
        endcase
        wr_d = (state_d == WR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign ram_addr   = addr_q;
    assign ram_w_notr = wr_q;
    assign ram_data   = wr_q ? buf_q : {WSZ{1'bz}};

endmodule

// File: tb/tb_dma_channel.sv
// Directed plus randomized bench for dma_channel with a behavioural RAM and a
// reference model that replays each copy word-by-word and predicts the bus trace.
module tb_dma_channel;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [7:0] src, dst, len;
    logic       busy, done, ram_w_notr;
    logic [7:0] ram_addr;
    wire  [7:0] ram_data;

    logic [7:0] mem   [256];
    logic [7:0] model [256];
    logic       pl_en;
    logic [7:0] pl_addr, pl_val;
    logic [7:0] eaddr;
    int         checks = 0;
    int         errors = 0;

    dma_channel #(.SZ(8), .WSZ(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
        .abort(abort), .busy(busy), .done(done), .ram_addr(ram_addr),
        .ram_w_notr(ram_w_notr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // RAM drives the bus whenever the DMA is not writing.
    assign ram_data = ram_w_notr ? 8'bz : mem[ram_addr];

    always @(posedge clk) begin
        if (ram_w_notr) mem[ram_addr] = ram_data;
        else if (pl_en) mem[pl_addr] = pl_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pre(input logic [7:0] a, input logic [7:0] v);
        pl_en = 1'b1; pl_addr = a; pl_val = v; model[a] = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic mem_cmp(input string tag);
        int diffs = 0;
        for (int j = 0; j < 256; j++) if (mem[j] !== model[j]) diffs++;
        chk(tag, diffs, 0);
    endtask

    // cut > 0 interrupts the transfer during cycle 'cut' (abort, or reset if use_rst).
    task automatic xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                        input int cut, input bit use_rst);
        int n, last, w, p, written;
        logic ew, ed;
        logic [7:0] a;
        n = l;
        last = (cut > 0) ? cut : 4 * n + 1;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l; abort = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst_n = 1'b1;
            if (k <= 4 * n) begin
                w = (k - 1) / 4; p = (k - 1) % 4;
                eaddr = (p == 0) ? 8'(s + w) : 8'(d + w);
                ew = (p == 2); ed = 1'b0;
            end else begin
                ew = 1'b0; ed = 1'b1;
            end
            chk($sformatf("busy@%0d", k), busy, 1);
            chk($sformatf("done@%0d", k), done, ed);
            chk($sformatf("wr@%0d", k), ram_w_notr, ew);
            chk($sformatf("addr@%0d", k), ram_addr, eaddr);
            if (k == cut) begin
                if (use_rst) rst_n = 1'b0; else abort = 1'b1;
            end else if ($urandom_range(2) == 0) begin
                start = 1'b1; src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        if (cut > 0 && use_rst) eaddr = 8'h00;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_wr", ram_w_notr, 0);
        chk("idle_addr", ram_addr, eaddr);
        chk("idle_bus", ram_data, mem[ram_addr]);
        written = (cut > 0) ? ((cut - 1) / 4 + (((cut - 1) % 4) >= 2 ? 1 : 0)) : n;
        for (int j = 0; j < written; j++) begin
            a = 8'(d + j);
            model[a] = model[8'(s + j)];
        end
        mem_cmp("mem_image");
    endtask

    initial begin
        int l, cut;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src = '0; dst = '0; len = '0; pl_en = 1'b0; pl_addr = '0; pl_val = '0;
        @(negedge clk);
        for (int j = 0; j < 256; j++) pre(8'(j), 8'($urandom));
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr", ram_w_notr, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_bus", ram_data, mem[0]);
        rst_n = 1'b1;
        eaddr = 8'h00;

        pre(8'h00, 8'h01); pre(8'h01, 8'h02); pre(8'h02, 8'h03);
        xfer(8'h00, 8'h10, 8'd3, 0, 1'b0);
        chk("basic_10", mem[8'h10], 8'h01);
        chk("basic_11", mem[8'h11], 8'h02);
        chk("basic_12", mem[8'h12], 8'h03);

        xfer(8'h05, 8'h06, 8'd0, 0, 1'b0);

        pre(8'hFE, 8'hAA); pre(8'hFF, 8'hBB);
        xfer(8'hFE, 8'hFF, 8'd3, 0, 1'b0);
        chk("wrap_00", mem[8'h00], 8'hAA);

        pre(8'h00, 8'h01); pre(8'h01, 8'h02); pre(8'h02, 8'h03); pre(8'h03, 8'h04);
        xfer(8'h00, 8'h01, 8'd3, 0, 1'b0);
        for (int j = 0; j < 4; j++) chk($sformatf("ovl_%0d", j), mem[j], 8'h01);

        xfer(8'h20, 8'h40, 8'd4, 6, 1'b0);

        @(negedge clk);
        start = 1'b1; abort = 1'b1; src = 8'h00; dst = 8'h80; len = 8'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_wr", ram_w_notr, 0);

        xfer(8'h30, 8'h50, 8'd4, 3, 1'b1);
        xfer(8'h60, 8'h70, 8'd5, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            l = $urandom_range(1, 20);
            cut = ($urandom_range(3) == 0) ? $urandom_range(1, 4 * l) : 0;
            xfer(8'($urandom), 8'($urandom), 8'(l), cut, 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
